// File: rtl/scoreboard_pkg.sv
// Shared scoreboard display constants, sequencer state encoding and BCD helper.
// Used by score_rotator and the display controller.
package scoreboard_pkg;

    localparam logic [3:0] DIGIT_OFF = 4'd10;
    localparam logic [3:0] DIGIT_P   = 4'd11;

    typedef enum logic {
        StBlink = 1'b0,
        StShow  = 1'b1
    } state_e;

    function automatic logic bcd_valid(input logic [3:0] digit);
        return digit <= 4'd9;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Free-running phase counter: counts 0..last while enabled, pulses tc on the last count.
// A synchronous clear wins over the enable.
module phase_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_1khz,
    input  logic             rst_ni,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] last,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;

    assign tc = en && (count_q == last);

    always_ff @(posedge clk_1khz or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= tc ? '0 : count_q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/score_rotator.sv
// Scoreboard display sequencer: blinks "P<n>" then shows each player's two BCD digits,
// with hold, jump-to-player, leading-zero blanking and invalid-digit suppression.
module score_rotator
    import scoreboard_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS     = 2,
    parameter int unsigned BLINK_TIME      = 500,
    parameter int unsigned DISPLAY_TIME    = 2000,
    parameter int unsigned BLINK_INTERVALS = 6,
    parameter bit          LZ_BLANK        = 1'b1
) (
    input  logic                     clk_1khz,
    input  logic                     rst_ni,
    input  logic [4*NUM_PLAYERS-1:0] tens_i,
    input  logic [4*NUM_PLAYERS-1:0] ones_i,
    input  logic                     hold_i,
    input  logic                     jump_i,
    input  logic [3:0]               jump_sel_i,
    output logic [3:0]               tens_o,
    output logic [3:0]               ones_o,
    output logic [3:0]               player_o,
    output logic                     show_o
);

    localparam int unsigned TMAX    = (BLINK_TIME > DISPLAY_TIME) ? BLINK_TIME : DISPLAY_TIME;
    localparam int unsigned TIMER_W = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int unsigned IW      = $clog2(BLINK_INTERVALS);

    localparam logic [3:0]         LAST_PLAYER   = 4'(NUM_PLAYERS - 1);
    localparam logic [IW-1:0]      LAST_INTERVAL = IW'(BLINK_INTERVALS - 1);
    localparam logic [TIMER_W-1:0] BLINK_LAST    = TIMER_W'(BLINK_TIME - 1);
    localparam logic [TIMER_W-1:0] SHOW_LAST     = TIMER_W'(DISPLAY_TIME - 1);

    state_e       state_q;
    logic [3:0]   player_q;
    logic [IW-1:0] interval_q;

    logic         jump_ok;
    logic         tc;
    logic [TIMER_W-1:0] timer_last;
    logic [3:0]   tens_sel, ones_sel, tens_d, ones_d;

    // Out-of-range jump targets are dropped completely.
    assign jump_ok    = jump_i && (jump_sel_i <= LAST_PLAYER);
    assign timer_last = (state_q == StShow) ? SHOW_LAST : BLINK_LAST;

    phase_timer #(
        .WIDTH (TIMER_W)
    ) u_phase_timer (
        .clk_1khz (clk_1khz),
        .rst_ni   (rst_ni),
        .en       (!hold_i),
        .clr      (jump_ok),
        .last     (timer_last),
        .tc       (tc)
    );

    always_ff @(posedge clk_1khz or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StBlink;
            player_q   <= '0;
            interval_q <= '0;
        end else if (jump_ok) begin
            state_q    <= StBlink;
            player_q   <= jump_sel_i;
            interval_q <= '0;
        end else if (tc) begin
            if (state_q == StBlink) begin
                if (interval_q == LAST_INTERVAL) begin
                    interval_q <= '0;
                    state_q    <= StShow;
                end else begin
                    interval_q <= interval_q + IW'(1);
                end
            end else begin
                state_q  <= StBlink;
                player_q <= (player_q == LAST_PLAYER) ? 4'd0 : player_q + 4'd1;
            end
        end
    end

    // Score digits are tracked live, so changes show even while held.
    always_comb begin
        tens_sel = '0;
        ones_sel = '0;
        for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
            if (player_q == 4'(k)) begin
                tens_sel = tens_i[4*k +: 4];
                ones_sel = ones_i[4*k +: 4];
            end
        end
        tens_d = DIGIT_OFF;
        ones_d = DIGIT_OFF;
        if (state_q == StBlink) begin
            if (!interval_q[0]) begin
                tens_d = DIGIT_P;
                ones_d = player_q + 4'd1;
            end
        end else begin
            if (bcd_valid(tens_sel) && !(LZ_BLANK && (tens_sel == 4'd0))) begin
                tens_d = tens_sel;
            end
            if (bcd_valid(ones_sel)) begin
                ones_d = ones_sel;
            end
        end
    end

    always_ff @(posedge clk_1khz or negedge rst_ni) begin
        if (!rst_ni) begin
            tens_o   <= DIGIT_OFF;
            ones_o   <= DIGIT_OFF;
            player_o <= '0;
            show_o   <= 1'b0;
        end else begin
            tens_o   <= tens_d;
            ones_o   <= ones_d;
            player_o <= player_q;
            show_o   <= (state_q == StShow);
        end
    end

endmodule

// File: tb/tb_score_rotator.sv
// Scoreboard bench for score_rotator: stimulus pushes per-edge expectations, a monitor
// pops and compares one entry after every rising edge.
module tb_score_rotator;

    localparam int unsigned NP = 3;

    logic              clk_1khz = 1'b0;
    logic              rst_ni   = 1'b0;
    logic [4*NP-1:0]   tens, ones, tens_n, ones_n;
    logic              hold = 1'b0, jump = 1'b0;
    logic [3:0]        jump_sel = 4'd0;
    logic [3:0]        tens_o, ones_o, player_o, n_tens_o, n_ones_o, n_player_o;
    logic              show_o, n_show_o;

    always #5 clk_1khz = ~clk_1khz;

    score_rotator #(
        .NUM_PLAYERS (NP), .BLINK_TIME (3), .DISPLAY_TIME (5), .BLINK_INTERVALS (4),
        .LZ_BLANK (1'b1)
    ) dut (
        .clk_1khz (clk_1khz), .rst_ni (rst_ni), .tens_i (tens), .ones_i (ones),
        .hold_i (hold), .jump_i (jump), .jump_sel_i (jump_sel),
        .tens_o (tens_o), .ones_o (ones_o), .player_o (player_o), .show_o (show_o)
    );

    score_rotator #(
        .NUM_PLAYERS (NP), .BLINK_TIME (3), .DISPLAY_TIME (5), .BLINK_INTERVALS (4),
        .LZ_BLANK (1'b0)
    ) dut_n (
        .clk_1khz (clk_1khz), .rst_ni (rst_ni), .tens_i (tens_n), .ones_i (ones_n),
        .hold_i (hold), .jump_i (jump), .jump_sel_i (jump_sel),
        .tens_o (n_tens_o), .ones_o (n_ones_o), .player_o (n_player_o), .show_o (n_show_o)
    );

    typedef struct {
        string      name;
        logic [3:0] t, o, p;
        logic       s;
        bit         chk_n;
        logic [3:0] nt, no;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_1khz);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check({e.name, ".tens"},   tens_o,   e.t);
                check({e.name, ".ones"},   ones_o,   e.o);
                check({e.name, ".player"}, player_o, e.p);
                check({e.name, ".show"},   {3'b0, show_o}, {3'b0, e.s});
                if (e.chk_n) begin
                    check({e.name, ".nlz_tens"}, n_tens_o, e.nt);
                    check({e.name, ".nlz_ones"}, n_ones_o, e.no);
                end
            end
        end
    end

    // Push the expectation for the coming rising edge, then wait to the next falling edge.
    task automatic step_n(input string nm, input logic [3:0] t, input logic [3:0] o,
                          input logic [3:0] p, input logic s, input bit chk,
                          input logic [3:0] nt, input logic [3:0] no);
        exp_t e;
        e.name = nm; e.t = t; e.o = o; e.p = p; e.s = s; e.chk_n = chk; e.nt = nt; e.no = no;
        q.push_back(e);
        @(negedge clk_1khz);
    endtask

    task automatic step(input string nm, input logic [3:0] t, input logic [3:0] o,
                        input logic [3:0] p, input logic s);
        step_n(nm, t, o, p, s, 1'b0, 4'd0, 4'd0);
    endtask

    // Four blink intervals of three cycles: P<n>, off, P<n>, off.
    task automatic blink(input string nm, input logic [3:0] p, input bit chk);
        logic [3:0] pn;
        pn = p + 4'd1;
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 3; c++) begin
                if (i % 2 == 0) step_n(nm, 4'd11, pn, p, 1'b0, chk, 4'd11, pn);
                else            step_n(nm, 4'd10, 4'd10, p, 1'b0, chk, 4'd10, 4'd10);
            end
        end
    endtask

    // Asynchronous reset away from any clock edge; release on a falling edge.
    task automatic do_reset(input string nm);
        @(posedge clk_1khz);
        #2 rst_ni = 1'b0;
        #1;
        check({nm, ".rst_tens"},   tens_o,   4'd10);
        check({nm, ".rst_ones"},   ones_o,   4'd10);
        check({nm, ".rst_player"}, player_o, 4'd0);
        check({nm, ".rst_show"},   {3'b0, show_o}, 4'd0);
        @(negedge clk_1khz);
        rst_ni = 1'b1;
    endtask

    initial begin
        logic [3:0] rt [3] = '{4'd1, 4'd10, 4'd4};
        logic [3:0] ro [3] = '{4'd2, 4'd7, 4'd5};
        logic [3:0] nt [3] = '{4'd0, 4'd10, 4'd9};
        logic [3:0] no [3] = '{4'd7, 4'd3, 4'd10};

        tens   = {4'd4, 4'd0, 4'd1};
        ones   = {4'd5, 4'd7, 4'd2};
        tens_n = {4'd9, 4'hC, 4'd0};
        ones_n = {4'hA, 4'd3, 4'd7};
        @(negedge clk_1khz);

        // Full rotation (51 cycles), then wrap to P1.
        do_reset("rot");
        for (int p = 0; p < 3; p++) begin
            blink("rot_blink", 4'(p), 1'b1);
            for (int c = 0; c < 5; c++)
                step_n("rot_show", rt[p], ro[p], 4'(p), 1'b1, 1'b1, nt[p], no[p]);
        end
        step_n("rot_wrap", 4'd11, 4'd1, 4'd0, 1'b0, 1'b1, 4'd11, 4'd1);

        // Hold for 10 cycles in SHOW while the ones digit changes.
        ones = {4'd5, 4'd7, 4'd3};
        do_reset("hold");
        blink("hold_blink", 4'd0, 1'b0);
        step("hold_show", 4'd1, 4'd3, 4'd0, 1'b1);
        hold = 1'b1;
        repeat (2) step("hold_frz", 4'd1, 4'd3, 4'd0, 1'b1);
        ones = {4'd5, 4'd7, 4'd4};
        repeat (8) step("hold_live", 4'd1, 4'd4, 4'd0, 1'b1);
        hold = 1'b0;
        repeat (4) step("hold_resume", 4'd1, 4'd4, 4'd0, 1'b1);
        step("hold_next", 4'd11, 4'd2, 4'd1, 1'b0);

        // Jump to player 2 mid-SHOW of player 0.
        ones = {4'd5, 4'd7, 4'd2};
        do_reset("jump");
        blink("jump_blink0", 4'd0, 1'b0);
        repeat (2) step("jump_show0", 4'd1, 4'd2, 4'd0, 1'b1);
        jump = 1'b1; jump_sel = 4'd2;
        step("jump_req", 4'd1, 4'd2, 4'd0, 1'b1);
        jump = 1'b0;
        blink("jump_blink2", 4'd2, 1'b0);
        repeat (5) step("jump_show2", 4'd4, 4'd5, 4'd2, 1'b1);
        step("jump_wrap", 4'd11, 4'd1, 4'd0, 1'b0);

        // Out-of-range jumps ignored; jump wins over hold at a terminal count.
        do_reset("jsel");
        step("jsel_p1", 4'd11, 4'd1, 4'd0, 1'b0);
        jump = 1'b1; jump_sel = 4'd5;
        step("jsel5", 4'd11, 4'd1, 4'd0, 1'b0);
        jump_sel = 4'd3;
        step("jsel3", 4'd11, 4'd1, 4'd0, 1'b0);
        jump = 1'b0;
        repeat (3) step("jsel_off", 4'd10, 4'd10, 4'd0, 1'b0);
        repeat (2) step("jsel_p1b", 4'd11, 4'd1, 4'd0, 1'b0);
        hold = 1'b1;
        repeat (2) step("jhold_frz", 4'd11, 4'd1, 4'd0, 1'b0);
        jump = 1'b1; jump_sel = 4'd1;
        step("jhold_req", 4'd11, 4'd1, 4'd0, 1'b0);
        jump = 1'b0;
        repeat (3) step("jhold_p2", 4'd11, 4'd2, 4'd1, 1'b0);
        hold = 1'b0;
        repeat (3) step("jhold_run", 4'd11, 4'd2, 4'd1, 1'b0);
        step("jhold_off", 4'd10, 4'd10, 4'd1, 1'b0);

        // Reset mid-BLINK of player 1, then restart at P1.
        do_reset("mid");
        blink("mid_blink0", 4'd0, 1'b0);
        repeat (5) step("mid_show0", 4'd1, 4'd2, 4'd0, 1'b1);
        repeat (3) step("mid_p2", 4'd11, 4'd2, 4'd1, 1'b0);
        step("mid_off", 4'd10, 4'd10, 4'd1, 1'b0);
        do_reset("midrst");
        repeat (3) step("restart_p1", 4'd11, 4'd1, 4'd0, 1'b0);
        repeat (3) step("restart_off", 4'd10, 4'd10, 4'd0, 1'b0);
        step("restart_p1b", 4'd11, 4'd1, 4'd0, 1'b0);

        repeat (2) @(negedge clk_1khz);
        n_total++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL queue_drain: got %0d entries left, expected 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
